cpu_mem_router: RTL

//  Downstream of the CPU shared-bus adapter: takes the single PicoRV32-style request (valid/addr/wdata/wstrb)
//  and decodes it to BRAM, peripheral register window or flash read port, then returns one registered
//  mem_ready pulse with read data. Also acks unmapped/illegal accesses and times out stalled slaves.

---
 rtl/cpu_mem_router_pkg.sv | 26 ++
 rtl/cpu_mem_router_if.sv | 21 ++
 rtl/cpu_mem_decode.sv | 18 +
 rtl/cpu_mem_router.sv | 108 ++++++++++
 4 files changed

// File: rtl/cpu_mem_router_pkg.sv
// cpu_mem_router_pkg: address map, region and FSM encodings shared by the router and its decoder
package cpu_mem_router_pkg;

    localparam logic [31:0] WIN64K_MASK = 32'hFFFF_0000;
    localparam logic [31:0] FLASH_MASK  = 32'hFF00_0000;
    localparam logic [31:0] BRAM_BASE   = 32'h0000_0000;
    localparam logic [31:0] PERIPH_BASE = 32'h0001_0000;
    localparam logic [31:0] FLASH_BASE  = 32'h1000_0000;

    typedef enum logic [1:0] {
        REGION_BRAM,
        REGION_PERIPH,
        REGION_FLASH,
        REGION_NONE
    } region_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BRAM,
        ST_PERIPH,
        ST_FLASH,
        ST_ERR,
        ST_RESP
    } state_e;

endpackage

// File: rtl/cpu_mem_router_if.sv
// cpu_mem_router_if: PicoRV32-style native memory bus between the CPU adapter and the router
interface cpu_mem_router_if;

    logic        cpu_mem_valid;
    logic [31:0] cpu_mem_addr;
    logic [31:0] cpu_mem_wdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        cpu_mem_ready;
    logic [31:0] cpu_mem_rdata;

    modport master (
        output cpu_mem_valid, cpu_mem_addr, cpu_mem_wdata, cpu_mem_wstrb,
        input  cpu_mem_ready, cpu_mem_rdata
    );

    modport slave (
        input  cpu_mem_valid, cpu_mem_addr, cpu_mem_wdata, cpu_mem_wstrb,
        output cpu_mem_ready, cpu_mem_rdata
    );

endinterface

// File: rtl/cpu_mem_decode.sv
// cpu_mem_decode: combinational address decode to target region plus illegal-access flag
module cpu_mem_decode
    import cpu_mem_router_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    output region_e     region,
    output logic        illegal
);

    always_comb begin
        region = (addr & WIN64K_MASK) == BRAM_BASE   ? REGION_BRAM   :
                 (addr & WIN64K_MASK) == PERIPH_BASE ? REGION_PERIPH :
                 (addr & FLASH_MASK)  == FLASH_BASE  ? REGION_FLASH  : REGION_NONE;
        illegal = region == REGION_NONE || (region == REGION_FLASH && wstrb != 4'd0);
    end

endmodule

// File: rtl/cpu_mem_router.sv
// cpu_mem_router: routes one CPU request to BRAM, peripheral window or flash and returns a registered ack
module cpu_mem_router
    import cpu_mem_router_pkg::*;
#(
    parameter int BRAM_AW = 12,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               reset,
    cpu_mem_router_if.slave    cpu,
    output logic               bram_en,
    output logic [BRAM_AW-1:0] bram_addr,
    output logic [3:0]         bram_wstrb,
    output logic [31:0]        bram_wdata,
    input  logic [31:0]        bram_rdata,
    output logic               periph_en,
    output logic [15:0]        periph_addr,
    output logic [3:0]         periph_wstrb,
    output logic [31:0]        periph_wdata,
    input  logic [31:0]        periph_rdata,
    input  logic               periph_ready,
    output logic               flash_read_valid,
    output logic [23:0]        flash_read_addr,
    input  logic [31:0]        flash_rdata,
    input  logic               flash_read_ready,
    output logic               bus_error,
    output logic [31:0]        bus_error_addr
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_e     state, next;
    region_e    region;
    logic       illegal, rd, start, slave_ack, expired;
    logic [7:0] cnt;

    cpu_mem_decode u_decode (
        .addr    (cpu.cpu_mem_addr),
        .wstrb   (cpu.cpu_mem_wstrb),
        .region  (region),
        .illegal (illegal)
    );

    assign rd        = cpu.cpu_mem_wstrb == 4'd0;
    assign start     = state == ST_IDLE && cpu.cpu_mem_valid;
    assign slave_ack = state == ST_PERIPH ? periph_ready : flash_read_ready;
    assign expired   = cnt == TMO;

    // BRAM is strobed straight from the decode so its 1-cycle read lands in ST_BRAM
    assign bram_en    = start && region == REGION_BRAM;
    assign bram_addr  = cpu.cpu_mem_addr[BRAM_AW+1:2];
    assign bram_wstrb = bram_en ? cpu.cpu_mem_wstrb : 4'd0;
    assign bram_wdata = cpu.cpu_mem_wdata;

    always_comb begin
        next = state;
        case (state)
            ST_IDLE: if (cpu.cpu_mem_valid)
                next = illegal                 ? ST_ERR    :
                       region == REGION_BRAM   ? ST_BRAM   :
                       region == REGION_PERIPH ? ST_PERIPH : ST_FLASH;
            ST_BRAM:             next = ST_RESP;
            ST_PERIPH, ST_FLASH: next = slave_ack ? ST_RESP : expired ? ST_ERR : state;
            ST_ERR:              next = ST_RESP;
            default:             next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt               <= 8'd0;
            cpu.cpu_mem_ready <= 1'b0;
            cpu.cpu_mem_rdata <= 32'd0;
            periph_en         <= 1'b0;
            periph_addr       <= 16'd0;
            periph_wstrb      <= 4'd0;
            periph_wdata      <= 32'd0;
            flash_read_valid  <= 1'b0;
            flash_read_addr   <= 24'd0;
            bus_error         <= 1'b0;
            bus_error_addr    <= 32'd0;
        end else begin
            cnt               <= (state == ST_PERIPH || state == ST_FLASH) ? cnt + 8'd1 : 8'd0;
            cpu.cpu_mem_ready <= next == ST_RESP;
            bus_error         <= state == ST_ERR;
            periph_en         <= next == ST_PERIPH;
            flash_read_valid  <= next == ST_FLASH;
            cpu.cpu_mem_rdata <= state == ST_BRAM                      ? (rd ? bram_rdata : 32'd0)   :
                                 state == ST_PERIPH && periph_ready    ? (rd ? periph_rdata : 32'd0) :
                                 state == ST_FLASH && flash_read_ready ? flash_rdata                 :
                                 state == ST_ERR                       ? 32'd0 : cpu.cpu_mem_rdata;
            if (state == ST_ERR)
                bus_error_addr <= cpu.cpu_mem_addr;
            if (start) begin
                periph_addr     <= cpu.cpu_mem_addr[15:0];
                periph_wstrb    <= cpu.cpu_mem_wstrb;
                periph_wdata    <= cpu.cpu_mem_wdata;
                flash_read_addr <= cpu.cpu_mem_addr[23:0];
            end
        end
    end

endmodule
